// File: rtl/hv_enable_seq.sv
// -----------------------------------------------------------------------------
// hv_enable_seq
//
// High-voltage enable controller for the HEMT bias supply channels.
//   * Per-channel and broadcast on/off commands from the NI command decoder.
//   * Per-channel trip inputs are filtered (TRIP_FILT consecutive high samples)
//     and latched into sticky alarms. An alarmed channel is forced off and
//     cannot be re-enabled until the host clears the alarm.
//   * A broadcast "all on" is executed as a staggered turn-on, one channel
//     every STAGGER_CYC clocks, to limit inrush current.
//
// Ports:
//   clk          master clock
//   rst          asynchronous active-high reset
//   addr         channel select; NCHAN = broadcast, above NCHAN = invalid
//   din          commanded state (1 = on)
//   enable_cntl  single-cycle command strobe
//   clr_alarm    single-cycle alarm-clear strobe (uses addr)
//   trip         raw per-channel trip inputs, active high, pre-synchronised
//   hv_en_n      registered HV enables, active low
//   alarm        registered sticky alarm status
//   busy         high while a staggered broadcast enable is in progress
//   cmd_rej      one-cycle pulse after a rejected command
// -----------------------------------------------------------------------------
module hv_enable_seq #(
    parameter int NCHAN       = 20,
    parameter int ADDR_W      = 5,
    parameter int TRIP_FILT   = 4,
    parameter int STAGGER_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              din,
    input  logic              enable_cntl,
    input  logic              clr_alarm,
    input  logic [NCHAN-1:0]  trip,
    output logic [NCHAN-1:0]  hv_en_n,
    output logic [NCHAN-1:0]  alarm,
    output logic              busy,
    output logic              cmd_rej
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(TRIP_FILT + 1);
    localparam int TMR_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_STAGGER = 1'b1;

    localparam logic [ADDR_W-1:0] BCAST_ADDR = ADDR_W'(NCHAN);
    localparam logic [ADDR_W-1:0] LAST_CH    = ADDR_W'(NCHAN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TRIP_FILT);
    localparam logic [CNT_W-1:0]  CNT_HIT    = CNT_W'(TRIP_FILT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NCHAN-1:0]  hv_en_n_q, hv_en_n_d;
    logic [NCHAN-1:0]  alarm_q,   alarm_d;
    logic              cmd_rej_q, cmd_rej_d;
    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] ch_idx_q,  ch_idx_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic [CNT_W-1:0]  cnt_q [NCHAN];
    logic [CNT_W-1:0]  cnt_d [NCHAN];

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [NCHAN-1:0] addr_sel;
    logic             addr_bcast;
    logic             addr_bad;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no latch is inferred.
        addr_sel   = '0;
        addr_bcast = (addr == BCAST_ADDR);
        addr_bad   = (addr > BCAST_ADDR);
        for (int i = 0; i < NCHAN; i++) begin
            addr_sel[i] = (addr == ADDR_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Trip filter and alarm latch
    // -------------------------------------------------------------------------
    logic [NCHAN-1:0] trip_hit;   // filter reaches TRIP_FILT on this edge
    logic [NCHAN-1:0] clr_hit;    // alarm clear accepted on this edge
    logic [NCHAN-1:0] alarmed;    // alarm before the edge or being set on it

    always_comb begin
        trip_hit = '0;
        clr_hit  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = '0;
            if (trip[i]) begin
                cnt_d[i]    = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
                // The current sample is the TRIP_FILT-th consecutive high one
                // once the count already holds TRIP_FILT-1 (or is saturated).
                trip_hit[i] = (cnt_q[i] >= CNT_HIT);
            end
            // A clear is honoured only while the trip itself has gone away,
            // so it can never collide with a same-edge alarm set.
            clr_hit[i] = clr_alarm && (addr_sel[i] || addr_bcast) && !trip[i];
        end
        alarmed = alarm_q | trip_hit;
        alarm_d = alarmed & ~clr_hit;
    end

    // -------------------------------------------------------------------------
    // Command decode and rejection
    // -------------------------------------------------------------------------
    logic cmd_bcast_on;
    logic cmd_bcast_off;
    logic cmd_single;
    logic single_alarm_rej;

    always_comb begin
        cmd_bcast_on     = enable_cntl && addr_bcast && din;
        cmd_bcast_off    = enable_cntl && addr_bcast && !din;
        cmd_single       = enable_cntl && !addr_bcast && !addr_bad;
        // Uses the pre-clear alarm view so an enable plus clear on the same
        // alarmed channel is still refused.
        single_alarm_rej = din && ((addr_sel & alarmed) != '0);

        cmd_rej_d = 1'b0;
        if (enable_cntl && addr_bad) begin
            cmd_rej_d = 1'b1;
        end
        if (clr_alarm && addr_bad) begin
            cmd_rej_d = 1'b1;
        end
        if (state_q == ST_STAGGER && (cmd_bcast_on || cmd_single)) begin
            cmd_rej_d = 1'b1;
        end
        if (state_q == ST_IDLE && cmd_single && single_alarm_rej) begin
            cmd_rej_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM and enable next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ch_idx_d  = ch_idx_q;
        tmr_d     = tmr_q;
        hv_en_n_d = hv_en_n_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_bcast_on) begin
                    state_d  = ST_STAGGER;
                    ch_idx_d = '0;
                    tmr_d    = '0;
                end
                if (cmd_single && !single_alarm_rej) begin
                    for (int i = 0; i < NCHAN; i++) begin
                        if (addr_sel[i]) begin
                            hv_en_n_d[i] = ~din;
                        end
                    end
                end
            end

            ST_STAGGER: begin
                // Slot timer: a channel is serviced whenever the timer sits
                // at zero, i.e. on the edge after entry and every
                // STAGGER_CYC edges thereafter.
                tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);
                if (tmr_q == '0) begin
                    for (int i = 0; i < NCHAN; i++) begin
                        if (ch_idx_q == ADDR_W'(i)) begin
                            hv_en_n_d[i] = 1'b0;
                        end
                    end
                    if (ch_idx_q == LAST_CH) begin
                        state_d  = ST_IDLE;
                        ch_idx_d = '0;
                    end else begin
                        ch_idx_d = ch_idx_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                ch_idx_d = '0;
                tmr_d    = '0;
            end
        endcase

        // Broadcast off wins from any state and aborts a running sequence.
        if (cmd_bcast_off) begin
            hv_en_n_d = '1;
            state_d   = ST_IDLE;
            ch_idx_d  = '0;
            tmr_d     = '0;
        end

        // Alarm override is applied last: an alarmed channel (including one
        // whose slot comes up while alarmed) is always driven off.
        hv_en_n_d = hv_en_n_d | alarmed;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv_en_n_q <= '1;
            alarm_q   <= '0;
            cmd_rej_q <= 1'b0;
            state_q   <= ST_IDLE;
            ch_idx_q  <= '0;
            tmr_q     <= '0;
            // NOTE: the filter counters are plain flops, not a RAM, so they
            // are reset along with everything else; a stale count would
            // otherwise shorten the first trip filter after reset.
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values computed above.
            hv_en_n_q <= hv_en_n_d;
            alarm_q   <= alarm_d;
            cmd_rej_q <= cmd_rej_d;
            state_q   <= state_d;
            ch_idx_q  <= ch_idx_d;
            tmr_q     <= tmr_d;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign hv_en_n = hv_en_n_q;
    assign alarm   = alarm_q;
    assign busy    = (state_q == ST_STAGGER);
    assign cmd_rej = cmd_rej_q;

endmodule

// File: doc/hv_enable_seq.md
Name: hv_enable_seq

Overview:
Parametrised successor channel high-voltage enable controller for the HEMT bias supply. It accepts per-channel and broadcast on/off commands from the NI interface and filters and latches per-channel trip inputs into sticky alarms. Alarms force the affected outputs off and block re-enable until the host clears them. A broadcast "all on" is sequenced as a staggered turn-on to limit inrush. It sits under hemt_top between the NI command decoder and the HV enable pins.

Parameters:
NCHAN, 20, number of HV channels (1..31).
ADDR_W, 5, channel address width; 2**ADDR_W must be greater than NCHAN.
TRIP_FILT, 4, consecutive high samples of trip[i] required to latch alarm[i] (>=1).
STAGGER_CYC, 1000, clk cycles between successive channel turn-ons in a broadcast enable (>=1).

Ports:
clk  input  1  master FPGA clock
rst  input  1  asynchronous, active-high reset
addr  input  ADDR_W  channel select; value NCHAN = broadcast; above NCHAN = invalid
din  input  1  commanded state, 1 = on
enable_cntl  input  1  single-cycle command strobe
clr_alarm  input  1  single-cycle alarm-clear strobe, uses addr (broadcast clears all)
trip  input  NCHAN  raw channel trip inputs, active high, pre-synchronised
hv_en_n  output  NCHAN  HV enables, active low, registered
alarm  output  NCHAN  latched alarm status, registered
busy  output  1  high while a staggered broadcast enable is in progress
cmd_rej  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting rst sets hv_en_n = all 1, alarm = 0, busy = 0, cmd_rej = 0, all filter counters = 0, FSM = IDLE, immediately and regardless of state.
  - Reset mid-stagger aborts the sequence.
- Trip filter, per channel:
  - Saturating counter increments on each edge where trip[i] = 1 and clears on any edge where trip[i] = 0.
  - alarm[i] sets on the edge at which trip[i] has been sampled high on TRIP_FILT consecutive edges. For TRIP_FILT = 1, that is the first high edge.
- Alarm override:
  - On the edge alarm[i] sets, hv_en_n[i] goes to 1 on the same edge. This overrides any same-cycle command or stagger step.
  - While alarm[i] = 1, hv_en_n[i] stays 1.
- Alarm clear:
  - clr_alarm with addr = i < NCHAN clears alarm[i] only if trip[i] = 0 in that cycle; otherwise the clear is ignored, alarm stays set and no cmd_rej.
  - Broadcast clear applies the same rule to every channel.
  - Invalid addr (> NCHAN) gives a cmd_rej pulse.
  - Clearing an alarm does not re-enable the channel.
- Single-channel command (enable_cntl, addr < NCHAN, FSM IDLE):
  - Sets hv_en_n[addr] <= ~din on the next edge (1-cycle latency).
  - din = 1 on an alarmed channel is rejected: hv_en_n unchanged, cmd_rej pulses.
  - "Alarmed" means the alarm value before the edge, or being set on that edge.
- Broadcast off (addr = NCHAN, din = 0):
  - All hv_en_n go to 1 on the next edge, from any state.
  - In STAGGER it also aborts the sequence: FSM returns to IDLE and busy falls on that edge.
- Broadcast on (addr = NCHAN, din = 1, FSM IDLE):
  - FSM IDLE -> STAGGER on command edge E0; busy = 1 from E0.
  - Channel k (0..NCHAN-1) is driven low at edge E0 + 1 + k*STAGGER_CYC.
  - A channel alarmed at its slot is skipped but still consumes its slot, so timing is deterministic.
  - On the edge that services channel NCHAN-1, FSM returns to IDLE and busy falls.
  - Channels already on remain on.
- Rejected commands (cmd_rej pulse, no other effect):
  - Any enable_cntl in STAGGER other than broadcast off.
  - Broadcast on in STAGGER.
  - enable_cntl with addr > NCHAN.
- cmd_rej is high for exactly the one cycle after the offending strobe.
- Simultaneous enable_cntl and clr_alarm: both are evaluated. The enable check uses the pre-clear alarm value, so enable-on plus clear on the same alarmed channel is rejected and the alarm clears.
- Alarm during stagger:
  - On a channel already on: forced off per the override rule.
  - On a channel not yet reached: that channel is skipped.
- State counters: stagger timer is a clog2(STAGGER_CYC) counter that wraps to 0 at each slot; channel index is ADDR_W bits and never exceeds NCHAN-1.

Test Plan:
Bench parameters for all scenarios: NCHAN=20, TRIP_FILT=4, STAGGER_CYC=8.
1. Reset release, then enable_cntl addr=3 din=1 -> hv_en_n = 20'hFFFF7 one edge later; addr=3 din=0 -> 20'hFFFFF; cmd_rej stays 0.
2. Channel 5 on; trip[5] high 3 cycles then low -> no alarm. Then high 4 cycles -> alarm[5] = 1 and hv_en_n[5] = 1 on the 4th edge. Enable addr=5 din=1 -> rejected, cmd_rej pulse. clr_alarm while trip high -> alarm stays 1; after trip low -> alarm 0, channel still off.
3. Broadcast on (addr=20, din=1) at E0 -> busy=1; channel k low at E0+1+8k; all 20 low at E0+153; busy falls at E0+153. Enable addr=2 during busy -> cmd_rej, no change.
4. Alarm channel 7 before broadcast on -> channel 7 stays high; channel 8 still turns on at E0+65.
5. Broadcast on, then broadcast off at E0+20 -> hv_en_n = 20'hFFFFF and busy=0 at E0+21; no further turn-ons.
6. Assert rst asynchronously mid-stagger -> outputs return to reset values without a clock edge. enable_cntl addr=21 -> cmd_rej pulse only.
